// File: rtl/resp_tree_pipe.sv
// Pipelined response fan-in tree: merges per-bank read responses into one master port,
// tracks the winning bank index and flags/counts illegal multi-bank collisions.
module resp_tree_pipe #(
    parameter int unsigned N_SLAVE    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned PIPELINE   = 0,
    parameter int unsigned CNT_WIDTH  = 8,
    localparam int unsigned D         = $clog2(N_SLAVE),
    localparam int unsigned SRC_W     = (D > 0) ? D : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_SLAVE-1:0]            data_r_valid_i,
    input  logic [N_SLAVE*DATA_WIDTH-1:0] data_r_rdata_i,
    input  logic                          cnt_clr_i,
    output logic                          data_r_valid_o,
    output logic [DATA_WIDTH-1:0]         data_r_rdata_o,
    output logic [SRC_W-1:0]              data_r_src_o,
    output logic                          coll_o,
    output logic [CNT_WIDTH-1:0]          coll_cnt_o
);

    localparam int unsigned P = 1 << D;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    // Heap-ordered tree: node 1 is the root, node i has children 2i/2i+1, leaves are P..2P-1.
    logic [2*P-1:1]        t_v;
    logic [2*P-1:1]        t_c;
    logic [DATA_WIDTH-1:0] t_d [1:2*P-1];
    logic [SRC_W-1:0]      t_s [1:2*P-1];

    for (genvar k = 0; k < P; k++) begin : g_leaf
        if (k < N_SLAVE) begin : g_in
            assign t_v[P+k] = data_r_valid_i[k];
            assign t_d[P+k] = data_r_rdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_pad
            assign t_v[P+k] = 1'b0;
            assign t_d[P+k] = {DATA_WIDTH{1'b0}};
        end
        assign t_c[P+k] = 1'b0;
        assign t_s[P+k] = {SRC_W{1'b0}};
    end

    for (genvar i = 1; i < P; i++) begin : g_node
        // Select bit lands at the node's height-1, so the root contributes the src MSB.
        localparam int unsigned POS = D - $clog2(i + 1);
        localparam logic [SRC_W-1:0] SEL_BIT = SRC_W'(1) << POS;

        logic                  v0, v1, nv, nc;
        logic [DATA_WIDTH-1:0] nd;
        logic [SRC_W-1:0]      ns;

        assign v0 = t_v[2*i];
        assign v1 = t_v[2*i+1];
        assign nv = v0 | v1;
        assign nc = (v0 & v1) | t_c[2*i] | t_c[2*i+1];
        assign nd = v0 ? t_d[2*i] : t_d[2*i+1];
        assign ns = v0 ? t_s[2*i] : (t_s[2*i+1] | SEL_BIT);

        if ((PIPELINE != 0) && (i != 1)) begin : g_reg
            logic                  v_q, c_q;
            logic [DATA_WIDTH-1:0] d_q;
            logic [SRC_W-1:0]      s_q;

            // Level register: valid/coll every cycle, payload only with a valid response.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    d_q <= {DATA_WIDTH{1'b0}};
                    s_q <= {SRC_W{1'b0}};
                end else begin
                    v_q <= nv;
                    c_q <= nc;
                    if (nv) begin
                        d_q <= nd;
                        s_q <= ns;
                    end
                end
            end

            assign t_v[i] = v_q;
            assign t_c[i] = c_q;
            assign t_d[i] = d_q;
            assign t_s[i] = s_q;
        end else begin : g_comb
            assign t_v[i] = nv;
            assign t_c[i] = nc;
            assign t_d[i] = nd;
            assign t_s[i] = ns;
        end
    end

    logic                  valid_q, coll_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic [SRC_W-1:0]      src_q;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

    // Counter steps on the same edge that loads coll_o, so the count lines up with the pulse.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = {CNT_WIDTH{1'b0}};
        end else if (t_c[1] && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Output register stage fed by the tree root.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            coll_q  <= 1'b0;
            rdata_q <= {DATA_WIDTH{1'b0}};
            src_q   <= {SRC_W{1'b0}};
            cnt_q   <= {CNT_WIDTH{1'b0}};
        end else begin
            valid_q <= t_v[1];
            coll_q  <= t_c[1];
            cnt_q   <= cnt_d;
            if (t_v[1]) begin
                rdata_q <= t_d[1];
                src_q   <= t_s[1];
            end
        end
    end

    assign data_r_valid_o = valid_q;
    assign data_r_rdata_o = rdata_q;
    assign data_r_src_o   = src_q;
    assign coll_o         = coll_q;
    assign coll_cnt_o     = cnt_q;

endmodule

// File: tb/tb_resp_tree_pipe.sv
// Scoreboard bench for resp_tree_pipe: three configurations driven with directed vectors,
// expected responses queued at issue time and popped by per-instance monitors.
module tb_resp_tree_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic [2:0]  src;
        logic        coll;
        int          due;
    } exp_t;

    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;

    // a: N_SLAVE=4, PIPELINE=0, CNT_WIDTH=2
    logic [3:0]   a_v;
    logic [127:0] a_d;
    logic         a_clr, a_vo, a_co;
    logic [31:0]  a_do;
    logic [1:0]   a_so, a_cnt;
    // b: N_SLAVE=8, PIPELINE=1
    logic [7:0]   b_v;
    logic [255:0] b_d;
    logic         b_clr, b_vo, b_co;
    logic [31:0]  b_do;
    logic [2:0]   b_so;
    logic [7:0]   b_cnt;
    // c: N_SLAVE=5, PIPELINE=1
    logic [4:0]   c_v;
    logic [159:0] c_d;
    logic         c_clr, c_vo, c_co;
    logic [31:0]  c_do;
    logic [2:0]   c_so;
    logic [7:0]   c_cnt;

    resp_tree_pipe #(.N_SLAVE(4), .DATA_WIDTH(32), .PIPELINE(0), .CNT_WIDTH(2)) u_a (
        .clk(clk), .rst(rst), .data_r_valid_i(a_v), .data_r_rdata_i(a_d), .cnt_clr_i(a_clr),
        .data_r_valid_o(a_vo), .data_r_rdata_o(a_do), .data_r_src_o(a_so),
        .coll_o(a_co), .coll_cnt_o(a_cnt));

    resp_tree_pipe #(.N_SLAVE(8), .DATA_WIDTH(32), .PIPELINE(1), .CNT_WIDTH(8)) u_b (
        .clk(clk), .rst(rst), .data_r_valid_i(b_v), .data_r_rdata_i(b_d), .cnt_clr_i(b_clr),
        .data_r_valid_o(b_vo), .data_r_rdata_o(b_do), .data_r_src_o(b_so),
        .coll_o(b_co), .coll_cnt_o(b_cnt));

    resp_tree_pipe #(.N_SLAVE(5), .DATA_WIDTH(32), .PIPELINE(1), .CNT_WIDTH(8)) u_c (
        .clk(clk), .rst(rst), .data_r_valid_i(c_v), .data_r_rdata_i(c_d), .cnt_clr_i(c_clr),
        .data_r_valid_o(c_vo), .data_r_rdata_o(c_do), .data_r_src_o(c_so),
        .coll_o(c_co), .coll_cnt_o(c_cnt));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [2:0] s, input logic c, input int due);
        exp_t e;
        e.data = d; e.src = s; e.coll = c; e.due = due;
        return e;
    endfunction

    always @(negedge clk) begin
        if (a_vo === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_valid", 32'd1, 32'd0);
            else begin
                ea = qa.pop_front();
                chk("a_data", a_do, ea.data);
                chk("a_src", {30'd0, a_so}, {29'd0, ea.src});
                chk("a_coll", {31'd0, a_co}, {31'd0, ea.coll});
                chk("a_latency", cyc, ea.due);
            end
        end
    end

    always @(negedge clk) begin
        if (b_vo === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_valid", 32'd1, 32'd0);
            else begin
                eb = qb.pop_front();
                chk("b_data", b_do, eb.data);
                chk("b_src", {29'd0, b_so}, {29'd0, eb.src});
                chk("b_coll", {31'd0, b_co}, {31'd0, eb.coll});
                chk("b_latency", cyc, eb.due);
            end
        end
    end

    always @(negedge clk) begin
        if (c_vo === 1'b1) begin
            if (qc.size() == 0) chk("c_unexpected_valid", 32'd1, 32'd0);
            else begin
                ec = qc.pop_front();
                chk("c_data", c_do, ec.data);
                chk("c_src", {29'd0, c_so}, {29'd0, ec.src});
                chk("c_coll", {31'd0, c_co}, {31'd0, ec.coll});
                chk("c_latency", cyc, ec.due);
            end
        end
    end

    initial begin
        rst = 1'b1;
        a_v = 4'd0; a_d = 128'd0; a_clr = 1'b0;
        b_v = 8'd0; b_d = 256'd0; b_clr = 1'b0;
        c_v = 5'd0; c_d = 160'd0; c_clr = 1'b0;
        for (int k = 0; k < 8; k++) b_d[k*32 +: 32] = 32'hB000_0000 + k;
        for (int k = 0; k < 5; k++) c_d[k*32 +: 32] = 32'hC000_0000 + k;
        tick();
        tick();
        rst = 1'b0;

        chk("rst_a_valid", {31'd0, a_vo}, 32'd0);
        chk("rst_a_rdata", a_do, 32'd0);
        chk("rst_a_src", {30'd0, a_so}, 32'd0);
        chk("rst_a_coll", {31'd0, a_co}, 32'd0);
        chk("rst_a_cnt", {30'd0, a_cnt}, 32'd0);
        chk("rst_b_valid", {31'd0, b_vo}, 32'd0);
        chk("rst_c_valid", {31'd0, c_vo}, 32'd0);

        // single response from bank 2, then hold while idle
        a_v = 4'b0100;
        a_d[64 +: 32] = 32'hCAFE_0002;
        qa.push_back(mk(32'hCAFE_0002, 3'd2, 1'b0, cyc + 1));
        tick();
        a_v = 4'd0;
        tick();
        chk("a_idle_valid", {31'd0, a_vo}, 32'd0);
        chk("a_hold_rdata", a_do, 32'hCAFE_0002);
        chk("a_hold_src", {30'd0, a_so}, 32'd2);

        // collision banks 1 and 3: lower index wins
        a_v = 4'b1010;
        a_d[32 +: 32] = 32'h11;
        a_d[96 +: 32] = 32'h33;
        qa.push_back(mk(32'h11, 3'd1, 1'b1, cyc + 1));
        tick();
        a_v = 4'd0;
        chk("a_cnt_after_coll", {30'd0, a_cnt}, 32'd1);
        a_clr = 1'b1;
        tick();
        a_clr = 1'b0;
        chk("a_cnt_cleared", {30'd0, a_cnt}, 32'd0);
        chk("a_coll_pulse_end", {31'd0, a_co}, 32'd0);

        // saturation with a 2-bit counter
        for (int i = 0; i < 5; i++) begin
            a_v = 4'b1010;
            qa.push_back(mk(32'h11, 3'd1, 1'b1, cyc + 1));
            tick();
            chk("a_cnt_sat", {30'd0, a_cnt}, (i < 3) ? (i + 1) : 3);
        end
        // clear and collision on the same edge: clear wins
        a_clr = 1'b1;
        qa.push_back(mk(32'h11, 3'd1, 1'b1, cyc + 1));
        tick();
        a_v = 4'd0;
        a_clr = 1'b0;
        chk("a_cnt_clr_wins", {30'd0, a_cnt}, 32'd0);

        // N=8 pipelined: banks 7,0,5 back to back, then two collisions
        b_v = 8'h80; qb.push_back(mk(32'hB000_0007, 3'd7, 1'b0, cyc + 3)); tick();
        b_v = 8'h01; qb.push_back(mk(32'hB000_0000, 3'd0, 1'b0, cyc + 3)); tick();
        b_v = 8'h20; qb.push_back(mk(32'hB000_0005, 3'd5, 1'b0, cyc + 3)); tick();
        b_v = 8'h60; qb.push_back(mk(32'hB000_0005, 3'd5, 1'b1, cyc + 3)); tick();
        b_v = 8'h88; qb.push_back(mk(32'hB000_0003, 3'd3, 1'b1, cyc + 3)); tick();
        b_v = 8'h00;
        repeat (5) tick();
        chk("b_cnt_two_coll", {24'd0, b_cnt}, 32'd2);
        chk("b_hold_rdata", b_do, 32'hB000_0003);

        // N=5 pipelined: sweep every real bank
        for (int k = 0; k < 5; k++) begin
            c_v = 5'd1 << k;
            qc.push_back(mk(32'hC000_0000 + k, k[2:0], 1'b0, cyc + 3));
            tick();
        end
        c_v = 5'd0;
        repeat (5) tick();
        chk("c_cnt_none", {24'd0, c_cnt}, 32'd0);

        chk("qa_drained", qa.size(), 32'd0);
        chk("qb_drained", qb.size(), 32'd0);
        chk("qc_drained", qc.size(), 32'd0);

        // reset while a response is inside the b pipeline: it must never emerge
        b_v = 8'h10;
        tick();
        b_v = 8'h00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_b_valid", {31'd0, b_vo}, 32'd0);
        chk("rstmid_b_rdata", b_do, 32'd0);
        chk("rstmid_b_src", {29'd0, b_so}, 32'd0);
        chk("rstmid_b_coll", {31'd0, b_co}, 32'd0);
        chk("rstmid_b_cnt", {24'd0, b_cnt}, 32'd0);
        chk("rstmid_a_rdata", a_do, 32'd0);
        repeat (6) begin
            tick();
            chk("rstmid_b_no_valid", {31'd0, b_vo}, 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
